// File: rtl/inst_axi_bridge_if.sv
// Bus interfaces for inst_axi_bridge: the IF-stage SRAM-like fetch port and the AXI read channels.
// inst_bus_err exists only when INST_AXI_BRIDGE_ERR_EN is defined.
interface inst_sram_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
`ifdef INST_AXI_BRIDGE_ERR_EN
    logic        inst_bus_err;
`endif

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
`ifdef INST_AXI_BRIDGE_ERR_EN
        , input inst_bus_err
`endif
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
`ifdef INST_AXI_BRIDGE_ERR_EN
        , output inst_bus_err
`endif
    );
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the IF-stage SRAM-like fetch port to single-beat AXI reads, in-order responses.
// Optional feature: define INST_AXI_BRIDGE_ERR_EN to add inst_bus_err (flags SLVERR/DECERR beats).
module inst_axi_bridge #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic       clk,
    input  logic       resetn,
    inst_sram_if.slave sram,
    axi_rd_if.master   axi
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_t;

    ar_state_t     state;
    ar_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   araddr_q;
    logic          addr_ok;
    logic          ar_hs;
    logic          r_hs;
    logic          r_real;
    logic          data_ok_q;
    logic [31:0]   rdata_q;

    assign ar_hs  = (state == AR_BUSY) & axi.arready;
    assign r_hs   = axi.rvalid & resetn;
    // A beat with nothing outstanding is unsolicited: consumed, never reported to IF.
    assign r_real = r_hs & (cnt != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= AR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_ok   = 1'b0;
        case (state)
            AR_IDLE: begin
                addr_ok = resetn & sram.inst_sram_req & (cnt < CNT_MAX);
                if (addr_ok) begin
                    state_nxt = AR_BUSY;
                end
            end
            AR_BUSY: begin
                if (ar_hs) begin
                    state_nxt = AR_IDLE;
                end
            end
            default: state_nxt = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            case ({addr_ok, r_real})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            araddr_q <= '0;
        end else if (addr_ok) begin
            araddr_q <= sram.inst_sram_addr;
        end
    end

    // Response data is held until the next real beat overwrites it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= r_real;
            if (r_real) begin
                rdata_q <= axi.rdata;
            end
        end
    end

`ifdef INST_AXI_BRIDGE_ERR_EN
    logic bus_err_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= r_real & axi.rresp[1];
        end
    end

    assign sram.inst_bus_err = bus_err_q;
`endif

    assign sram.inst_sram_addr_ok = addr_ok;
    assign sram.inst_sram_data_ok = data_ok_q;
    assign sram.inst_sram_rdata   = rdata_q;

    assign axi.arid    = 4'd0;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'd0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = (state == AR_BUSY);
    assign axi.rready  = resetn;

    logic unused_inputs;
`ifdef INST_AXI_BRIDGE_ERR_EN
    assign unused_inputs = ^{sram.inst_sram_wr, sram.inst_sram_size, sram.inst_sram_wstrb,
                             sram.inst_sram_wdata, axi.rid, axi.rlast, axi.rresp[0]};
`else
    assign unused_inputs = ^{sram.inst_sram_wr, sram.inst_sram_size, sram.inst_sram_wstrb,
                             sram.inst_sram_wdata, axi.rid, axi.rlast, axi.rresp};
`endif
endmodule

// File: tb/tb_inst_axi_bridge.sv
// Scoreboard bench for inst_axi_bridge: random IF requests and a random AXI slave, checked against
// a transaction-level model of accepted fetches, outstanding beats and in-order returned words.
module tb_inst_axi_bridge;
    localparam int MAX = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    inst_sram_if sram();
    axi_rd_if    axi();

    inst_axi_bridge #(.MAX_OUTSTANDING(MAX)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sram   (sram),
        .axi    (axi)
    );

    int checks = 0;
    int failures = 0;

    int p_req, p_ar, p_r, p_spur;
    logic [31:0] dir_q[$];

    logic [31:0] sb_q[$];
    logic [31:0] slv_q[$];
    int          outst;
    bit          ar_pend;
    logic [31:0] pend_addr;
    bit          dok_next;
    logic [31:0] exp_rdata;
    bit          acc_last;
    int          dut_acc;

    // Slave memory contents; the first word is the boot instruction used in the single-fetch case.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1C00_0000) return 32'h0280_0C0C;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic bit err_of(input logic [31:0] a);
        return a[3] ^ a[6];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock of stimulus: IF requester plus AXI read slave.
    task automatic applyStimulus(input bit rst_n);
        logic [31:0] a;
        @(posedge clk);
        #1;
        resetn = rst_n;
        if (!(sram.inst_sram_req && !acc_last)) begin
            if (dir_q.size() > 0) begin
                sram.inst_sram_req  = 1'b1;
                sram.inst_sram_addr = dir_q.pop_front();
            end else begin
                sram.inst_sram_req  = ($urandom_range(99) < p_req);
                sram.inst_sram_addr = 32'h1C00_0000 + {20'd0, $urandom_range(1023), 2'b00};
            end
        end
        sram.inst_sram_wr    = 1'($urandom);
        sram.inst_sram_size  = 2'($urandom);
        sram.inst_sram_wstrb = 4'($urandom);
        sram.inst_sram_wdata = $urandom;
        axi.arready = ($urandom_range(99) < p_ar);
        axi.rvalid  = 1'b0;
        axi.rdata   = $urandom;
        axi.rresp   = 2'($urandom);
        axi.rid     = 4'($urandom);
        axi.rlast   = 1'($urandom);
        if (slv_q.size() > 0 && $urandom_range(99) < p_r) begin
            a = slv_q.pop_front();
            axi.rvalid = 1'b1;
            axi.rdata  = mem_word(a);
            axi.rresp  = {err_of(a), 1'($urandom)};
        end else if (slv_q.size() == 0 && outst == 0 && $urandom_range(99) < p_spur) begin
            axi.rvalid = 1'b1;
        end
    endtask

    // Monitor / scoreboard: compares every cycle mid-period, then advances the model.
    initial begin
        logic [31:0] a;
        bit exp_ok;
        bit r_real;
        bit exp_err;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                checkOutput("addr_ok_in_reset", {31'd0, sram.inst_sram_addr_ok}, 32'd0);
                checkOutput("rready_in_reset", {31'd0, axi.rready}, 32'd0);
                sb_q.delete();
                slv_q.delete();
                outst     = 0;
                ar_pend   = 1'b0;
                dok_next  = 1'b0;
                exp_rdata = 32'd0;
                acc_last  = 1'b0;
            end else begin
                exp_ok = sram.inst_sram_req && !ar_pend && (outst < MAX);
                checkOutput("addr_ok", {31'd0, sram.inst_sram_addr_ok}, {31'd0, exp_ok});
                checkOutput("arvalid", {31'd0, axi.arvalid}, {31'd0, ar_pend});
                if (ar_pend) checkOutput("araddr", axi.araddr, pend_addr);
                checkOutput("rready", {31'd0, axi.rready}, 32'd1);
                checkOutput("ar_const", {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock,
                                         axi.arcache, axi.arprot, 6'd0},
                            {4'd0, 8'd0, 3'b010, 2'b01, 2'd0, 4'd0, 3'd0, 6'd0});
                exp_err = 1'b0;
                if (dok_next) begin
                    a = sb_q.pop_front();
                    exp_rdata = mem_word(a);
                    exp_err = err_of(a);
                end
                checkOutput("data_ok", {31'd0, sram.inst_sram_data_ok}, {31'd0, dok_next});
                checkOutput("rdata", sram.inst_sram_rdata, exp_rdata);
`ifdef INST_AXI_BRIDGE_ERR_EN
                checkOutput("bus_err", {31'd0, sram.inst_bus_err}, {31'd0, exp_err});
`endif
                if (sram.inst_sram_addr_ok) dut_acc++;
                r_real = axi.rvalid && (outst > 0);
                if (ar_pend && axi.arready) begin
                    slv_q.push_back(axi.araddr);
                    ar_pend = 1'b0;
                end
                if (exp_ok) begin
                    sb_q.push_back(sram.inst_sram_addr);
                    pend_addr = sram.inst_sram_addr;
                    ar_pend   = 1'b1;
                    outst++;
                end
                acc_last = exp_ok;
                dok_next = r_real;
                if (r_real) outst--;
            end
        end
    end

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1);
    endtask

    initial begin
        sram.inst_sram_req = 1'b0;
        sram.inst_sram_addr = 32'd0;
        sram.inst_sram_wr = 1'b0;
        sram.inst_sram_size = 2'd0;
        sram.inst_sram_wstrb = 4'd0;
        sram.inst_sram_wdata = 32'd0;
        axi.arready = 1'b0;
        axi.rvalid = 1'b0;
        axi.rdata = 32'd0;
        axi.rresp = 2'd0;
        axi.rid = 4'd0;
        axi.rlast = 1'b0;
        p_req = 0; p_ar = 100; p_r = 100; p_spur = 0;
        repeat (3) applyStimulus(1'b0);

        // Single fetch with an immediately responding slave.
        dir_q.push_back(32'h1C00_0000);
        runCycles(8);

        // AR backpressure while IF keeps requesting.
        p_ar = 0; p_req = 100;
        dir_q.push_back(32'h1C00_0040);
        runCycles(5);
        p_ar = 100; p_req = 0;
        runCycles(10);

        // Outstanding limit with the slave withholding responses.
        p_r = 0; p_req = 100;
        dut_acc = 0;
        runCycles(12);
        checkOutput("limit_accepts", dut_acc, MAX);
        p_r = 100; p_req = 0;
        runCycles(12);

        // Ordering of two back-to-back fetches.
        dir_q.push_back(32'h1C00_0000);
        dir_q.push_back(32'h1C00_0004);
        runCycles(10);

        // Reset with a fetch outstanding, then unsolicited beats.
        p_r = 0;
        dir_q.push_back(32'h1C00_0008);
        runCycles(3);
        applyStimulus(1'b0);
        p_spur = 100;
        runCycles(5);

        // Randomised traffic with occasional resets.
        p_req = 60; p_ar = 50; p_r = 40; p_spur = 5;
        for (int i = 0; i < 3000; i++) applyStimulus($urandom_range(199) != 0);

        // Drain everything still in flight, bounded.
        p_req = 0; p_ar = 100; p_r = 100; p_spur = 0;
        for (int i = 0; i < 50 && (sb_q.size() > 0 || ar_pend); i++) applyStimulus(1'b1);
        runCycles(3);
        checkOutput("drain_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
